// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - appliance run sequencer: timer countdown, heater/motor/fan drives
// Latches settings on start, counts minutes via a prescaler, sequences IDLE/RUN/PAUSE/DONE.
module run_sequencer #(
  parameter int TICKS_PER_MIN = 10,
  parameter int HYST          = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [4:0] temp_set,
  input  logic [4:0] cap_set,
  input  logic [4:0] fan_set,
  input  logic [4:0] timer_set,
  input  logic [4:0] temp_meas,
  output logic [1:0] state,
  output logic [4:0] remaining,
  output logic       heater_on,
  output logic       motor_on,
  output logic       fan_pwm,
  output logic       done
);

  localparam int            PW      = $clog2(TICKS_PER_MIN);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_MIN - 1);
  localparam logic [5:0]    HYST6   = 6'(HYST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    rem_q, rem_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [4:0]    pwm_cnt_q, pwm_cnt_d;
  logic [4:0]    temp_lat_q, temp_lat_d;
  logic [4:0]    cap_lat_q, cap_lat_d;
  logic [4:0]    fan_lat_q, fan_lat_d;
  logic          heater_q, heater_d;
  logic          motor_q, motor_d;
  logic          fan_q, fan_d;
  logic          done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= 5'd0;
      pre_q      <= '0;
      pwm_cnt_q  <= 5'd0;
      temp_lat_q <= 5'd0;
      cap_lat_q  <= 5'd0;
      fan_lat_q  <= 5'd0;
      heater_q   <= 1'b0;
      motor_q    <= 1'b0;
      fan_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      pre_q      <= pre_d;
      pwm_cnt_q  <= pwm_cnt_d;
      temp_lat_q <= temp_lat_d;
      cap_lat_q  <= cap_lat_d;
      fan_lat_q  <= fan_lat_d;
      heater_q   <= heater_d;
      motor_q    <= motor_d;
      fan_q      <= fan_d;
      done_q     <= done_d;
    end
  end

  // Stop has priority over start in every state that looks at both.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    pre_d      = pre_q;
    temp_lat_d = temp_lat_q;
    cap_lat_d  = cap_lat_q;
    fan_lat_d  = fan_lat_q;
    case (state_q)
      S_IDLE: begin
        if (start && (timer_set != 5'd0)) begin
          state_d    = S_RUN;
          rem_d      = timer_set;
          pre_d      = '0;
          temp_lat_d = temp_set;
          cap_lat_d  = cap_set;
          fan_lat_d  = fan_set;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_PAUSE;
        end else if (pre_q == PRE_MAX) begin
          pre_d = '0;
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) state_d = S_DONE;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          rem_d   = 5'd0;
        end else if (start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (start || stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Drives are computed from the upcoming state so they never lag a state change.
  always_comb begin
    heater_d = 1'b0;
    if (state_d == S_RUN) begin
      if (({1'b0, temp_meas} + HYST6) < {1'b0, temp_lat_d}) begin
        heater_d = 1'b1;
      end else if ({1'b0, temp_meas} >= {1'b0, temp_lat_d}) begin
        heater_d = 1'b0;
      end else begin
        heater_d = heater_q;
      end
    end
    motor_d   = (state_d == S_RUN) && (cap_lat_d != 5'd0);
    fan_d     = (state_d == S_RUN) && (pwm_cnt_q < fan_lat_d);
    done_d    = (state_d == S_DONE);
    pwm_cnt_d = pwm_cnt_q + 5'd1;
  end

  assign state     = state_q;
  assign remaining = rem_q;
  assign heater_on = heater_q;
  assign motor_on  = motor_q;
  assign fan_pwm   = fan_q;
  assign done      = done_q;

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - scoreboard bench for run_sequencer
// A behavioural model pushes expected outputs per driven cycle; they are popped after the edge.
module tb_run_sequencer;

  localparam int TPM  = 4;
  localparam int HYST = 1;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [4:0] temp_set, cap_set, fan_set, timer_set, temp_meas;
  logic [1:0] state;
  logic [4:0] remaining;
  logic       heater_on, motor_on, fan_pwm, done;

  run_sequencer #(.TICKS_PER_MIN(TPM), .HYST(HYST)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .temp_set(temp_set), .cap_set(cap_set), .fan_set(fan_set),
    .timer_set(timer_set), .temp_meas(temp_meas),
    .state(state), .remaining(remaining), .heater_on(heater_on),
    .motor_on(motor_on), .fan_pwm(fan_pwm), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [4:0] rem;
    logic       heat;
    logic       motor;
    logic       fan;
    logic       dn;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [1:0] m_state;
  logic [4:0] m_rem, m_pwm, m_temp, m_cap, m_fan;
  int         m_pre;
  logic       m_heat, m_motor, m_fanout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_t       e;
    logic [4:0] pwm_now;
    logic       in_run;
    if (rst) begin
      m_state = 2'd0; m_rem = 5'd0; m_pre = 0; m_pwm = 5'd0;
      m_temp = 5'd0; m_cap = 5'd0; m_fan = 5'd0;
      m_heat = 1'b0; m_motor = 1'b0; m_fanout = 1'b0;
    end else begin
      pwm_now = m_pwm;
      case (m_state)
        2'd0: if (start && timer_set != 5'd0) begin
          m_state = 2'd1; m_rem = timer_set; m_pre = 0;
          m_temp = temp_set; m_cap = cap_set; m_fan = fan_set;
        end
        2'd1: begin
          if (stop) m_state = 2'd2;
          else if (m_pre == TPM - 1) begin
            m_pre = 0;
            m_rem = m_rem - 5'd1;
            if (m_rem == 5'd0) m_state = 2'd3;
          end else m_pre = m_pre + 1;
        end
        2'd2: begin
          if (stop) begin m_state = 2'd0; m_rem = 5'd0; end
          else if (start) m_state = 2'd1;
        end
        default: if (start || stop) m_state = 2'd0;
      endcase
      in_run = (m_state == 2'd1);
      if (!in_run) m_heat = 1'b0;
      else if (int'(temp_meas) + HYST < int'(m_temp)) m_heat = 1'b1;
      else if (int'(temp_meas) >= int'(m_temp)) m_heat = 1'b0;
      m_motor  = in_run && (m_cap != 5'd0);
      m_fanout = in_run && (pwm_now < m_fan);
      m_pwm    = pwm_now + 5'd1;
    end
    e.st = m_state; e.rem = m_rem; e.heat = m_heat;
    e.motor = m_motor; e.fan = m_fanout; e.dn = (m_state == 2'd3);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("remaining", 32'(remaining), 32'(e.rem));
      check("heater_on", 32'(heater_on), 32'(e.heat));
      check("motor_on", 32'(motor_on), 32'(e.motor));
      check("fan_pwm", 32'(fan_pwm), 32'(e.fan));
      check("done", 32'(done), 32'(e.dn));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  int seq_t[5];
  int seq_h[5];
  int cnt;
  int fan_hi;
  int motor_hi;

  initial begin
    seq_t = '{18, 19, 20, 19, 18};
    seq_h = '{1, 1, 0, 0, 1};
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    temp_set = 5'd0; cap_set = 5'd0; fan_set = 5'd0; timer_set = 5'd0; temp_meas = 5'd0;

    // 1: reset with random inputs, then idle
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); stop = 1'($urandom);
      temp_set = 5'($urandom); cap_set = 5'($urandom); fan_set = 5'($urandom);
      timer_set = 5'($urandom); temp_meas = 5'($urandom);
      tick();
    end
    check("reset_state", 32'(state), 32'd0);
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("idle_remaining", 32'(remaining), 32'd0);

    // 2: full cycle, timer 3
    temp_set = 5'd20; cap_set = 5'd5; fan_set = 5'd8; timer_set = 5'd3; temp_meas = 5'd25;
    pulse_start();
    check("s2_run", 32'(state), 32'd1);
    check("s2_rem3", 32'(remaining), 32'd3);
    for (int i = 0; i < 4; i++) tick();
    check("s2_rem2", 32'(remaining), 32'd2);
    for (int i = 0; i < 4; i++) tick();
    check("s2_rem1", 32'(remaining), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("s2_done_state", 32'(state), 32'd3);
    check("s2_done", 32'(done), 32'd1);
    pulse_start();
    check("s2_back_idle", 32'(state), 32'd0);
    check("s2_done_clr", 32'(done), 32'd0);

    // 3: pause with prescaler held at 1, resume, then abort
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    pulse_stop();
    check("s3_pause", 32'(state), 32'd2);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("s3_hold_rem", 32'(remaining), 32'd2);
      check("s3_drives", 32'({heater_on, motor_on, fan_pwm}), 32'd0);
    end
    pulse_start();
    cnt = 0;
    while (state != 2'd3 && cnt < 20) begin tick(); cnt++; end
    check("s3_resume_to_done", 32'(cnt), 32'd7);
    pulse_start();
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    pulse_stop();
    pulse_stop();
    check("s3_abort_state", 32'(state), 32'd0);
    check("s3_abort_rem", 32'(remaining), 32'd0);

    // 4: heater hysteresis, long run
    timer_set = 5'd31; temp_meas = 5'd25;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      temp_meas = 5'(seq_t[i]);
      tick();
      check("s4_heater", 32'(heater_on), 32'(seq_h[i]));
    end

    // 5/6: fan duty, and mid-run setting changes have no effect
    fan_hi = 0;
    for (int i = 0; i < 32; i++) begin tick(); fan_hi += int'(fan_pwm); end
    check("s5_fan8", 32'(fan_hi), 32'd8);
    fan_set = 5'd31; temp_set = 5'd0; cap_set = 5'd0;
    fan_hi = 0;
    for (int i = 0; i < 32; i++) begin tick(); fan_hi += int'(fan_pwm); end
    check("s6_fan_latched", 32'(fan_hi), 32'd8);
    check("s6_motor_latched", 32'(motor_on), 32'd1);

    // 6: start+stop together in RUN pauses
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("s6_startstop_pause", 32'(state), 32'd2);
    pulse_stop();

    // 5: fan 0 and cap 0
    fan_set = 5'd0; cap_set = 5'd0;
    pulse_start();
    fan_hi = 0; motor_hi = 0;
    for (int i = 0; i < 32; i++) begin
      tick(); fan_hi += int'(fan_pwm); motor_hi += int'(motor_on);
    end
    check("s5_fan0", 32'(fan_hi), 32'd0);
    check("s5_motor0", 32'(motor_hi), 32'd0);

    // reset mid-RUN
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrun_reset", 32'({state, remaining, heater_on, motor_on, fan_pwm, done}), 32'd0);

    // 6: start with timer 0 stays idle
    timer_set = 5'd0;
    pulse_start();
    tick();
    check("s6_timer0_idle", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Downstream stage of the settings controller.
- Consumes the four 5-bit settings (temp, cap, fan, timer) and runs one appliance cycle from start to finish.
- Counts down the timer in minute ticks and drives heater, motor and fan-PWM outputs.
- Provides start/stop/pause sequencing and a done indication.

Parameters:
TICKS_PER_MIN, 10, clk cycles per timer minute (small default for simulation; set ≥2)
HYST, 1, heater hysteresis band in temperature units (0..7)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  start/resume request, sampled each cycle
stop  input  1  pause/abort request, sampled each cycle
temp_set  input  5  temperature setpoint from settings stage
cap_set  input  5  capacity setting; 0 = motor disabled
fan_set  input  5  fan speed setting, PWM duty in 1/32 steps
timer_set  input  5  cycle duration in minutes
temp_meas  input  5  measured temperature
state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
remaining  output  5  minutes left
heater_on  output  1  heater drive
motor_on  output  1  motor drive
fan_pwm  output  1  fan PWM drive
done  output  1  high while in DONE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. Every output is registered.
- Reset values: state=IDLE, remaining=0, heater_on=0, motor_on=0, fan_pwm=0, done=0. Reset also clears the prescaler, the PWM counter and the latched settings.
- Reset wins over all other inputs. Reset mid-RUN gives all-zero outputs on the next edge.
- IDLE:
  - start=1 and timer_set≠0 → RUN on the next edge.
  - On that edge: remaining←timer_set, prescaler←0, and temp/cap/fan settings are latched.
  - start with timer_set=0 → stay IDLE.
- RUN:
  - Prescaler counts 0..TICKS_PER_MIN-1.
  - On wrap: remaining decrements.
  - If remaining=1 at wrap → remaining←0, state←DONE.
  - stop=1 → PAUSE on the next edge; prescaler and remaining hold.
  - start and stop asserted in the same cycle: stop wins.
  - Setting inputs are ignored while in RUN; latched values are used.
- PAUSE:
  - start (with stop=0) → RUN; the prescaler resumes from its held value.
  - stop → IDLE; remaining←0 (abort).
  - All drives are 0.
- DONE:
  - done=1; remaining=0; all drives 0.
  - start or stop → IDLE on the next edge; done←0.
- heater_on, valid only in RUN (0 in every other state):
  - Compare at 6 bits.
  - Set when temp_meas+HYST < temp_lat.
  - Clear when temp_meas ≥ temp_lat.
  - Otherwise hold.
  - One-cycle latency from temp_meas.
  - Cleared on leaving RUN.
- motor_on: 1 iff next state is RUN and cap_lat≠0 (registered; asserted together with the state=RUN transition).
- fan_pwm:
  - 5-bit free-running pwm_cnt 0..31, wraps to 0.
  - fan_pwm ← (state==RUN) && (pwm_cnt < fan_lat).
  - fan_lat=0 → always 0; 31 → 31/32 high.
- Prescaler is in reset state (0) on every RUN entry from IDLE; it is not reset on resume from PAUSE.

Test Plan:
1. rst=1 with random inputs for 3 cycles → all outputs 0, state=00; release rst, no start → outputs remain 0.
2. TICKS_PER_MIN=4, timer_set=3, 1-cycle start pulse:
   - state=01, remaining=3.
   - remaining=2 after 4 further cycles, 1 after 8.
   - state=11, done=1 after 12 cycles.
   - Then a start pulse → state=00, done=0.
3. Pause and abort, run from scenario 2 conditions:
   - At remaining=2, stop pulse → state=10; remaining stays 2 for 10 cycles; motor/heater/fan 0.
   - start → RUN; DONE follows 8 cycles later minus the prescaler count held at pause.
   - Repeat the pause, then stop in PAUSE → IDLE, remaining=0.
4. Heater hysteresis, HYST=1, temp_set=20, in RUN: drive temp_meas 18,19,20,19,18 → heater_on 1,1,0,0,1, each one cycle after the corresponding input.
5. Fan PWM, fan_set=8 in RUN → fan_pwm high exactly 8 of every 32 cycles. fan_set=0 → never high. cap_set=0 → motor_on stays 0 throughout RUN.
6. Edge cases:
   - start with timer_set=0 → stays IDLE.
   - start+stop in the same cycle in RUN → PAUSE.
   - Change temp_set/fan_set mid-RUN → no effect on outputs.
